muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 32 +++
 rtl/muldiv_datapath.sv | 104 ++++++++++
 rtl/muldiv_ctrl.sv | 96 +++++++++
 tb/tb_muldiv_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // rs1 is a signed operand for every op except MULHU/DIVU/REMU
  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  // rs2 is signed only for MUL/MULH/DIV/REM
  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up.
module muldiv_datapath
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            fast,
  output logic [XLEN-1:0] res
);

  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2:0]        op;
  logic              neg_p;
  logic              neg_q;
  logic              neg_r;

  logic              sa, sb;
  logic [XLEN-1:0]   a_in, b_in;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_val;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic              fits;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   sel;

  // operand magnitudes, fast-path detection and per-step arithmetic
  always_comb begin
    sa       = rs1_signed(funct3) & rs1[XLEN-1];
    sb       = rs2_signed(funct3) & rs2[XLEN-1];
    a_in     = sa ? -rs1 : rs1;
    b_in     = sb ? -rs2 : rs2;
    div_zero = funct3[2] && (rs2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1 == MINV) && (rs2 == '1);
    fast     = div_zero | div_ovf;
    if (funct3[1]) fast_val = div_zero ? rs1 : '0;
    else           fast_val = div_zero ? '1 : MINV;
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, b_mag};
    // partial remainder < divisor keeps the difference inside XLEN+1 signed range,
    // so the top bit is a true borrow
    fits     = ~trial[XLEN];
    prod_fix = neg_p ? -acc : acc;
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = neg_r ? -rem : rem;
    case (op)
      F3_MUL:                        sel = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  sel = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               sel = quo_fix;
      default:                       sel = rem_fix;
    endcase
  end

  // operand latch, one radix-2 step per cycle, signed result fix-up
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      rem   <= '0;
      quo   <= '0;
      a_mag <= '0;
      b_mag <= '0;
      op    <= '0;
      neg_p <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
    end else if (load) begin
      a_mag <= a_in;
      b_mag <= b_in;
      op    <= funct3;
      neg_p <= sa ^ sb;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      acc   <= {{XLEN{1'b0}}, b_in};
      rem   <= '0;
      quo   <= a_in;
      if (fast) res <= fast_val;
    end else if (step) begin
      acc <= {mul_sum, acc[XLEN-1:1]};
      rem <= fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      quo <= {quo[XLEN-2:0], fits};
    end else if (fix) begin
      res <= sel;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: IDLE -> CALC(32) -> FIX -> DONE, with a
// divide-by-zero / signed-overflow shortcut straight from IDLE to DONE.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  state_t          state;
  logic [4:0]      count;
  logic            dp_load, dp_step, dp_fix, dp_fast;
  logic [XLEN-1:0] dp_res;

  assign stall = start & ~done;

  // datapath strobes follow the current state; flush suppresses them
  always_comb begin
    dp_load = (state == ST_IDLE) && start && !flush;
    dp_step = (state == ST_CALC) && !flush;
    dp_fix  = (state == ST_FIX)  && !flush;
  end

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load),
    .step   (dp_step),
    .fix    (dp_fix),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .fast   (dp_fast),
    .res    (dp_res)
  );

  // FSM with registered busy/done/result; done and result are registered on
  // the edge that leaves DONE, so the pulse lands one cycle after DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              count <= '0;
              if (dp_fast) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end else begin
                state <= ST_CALC;
                busy  <= 1'b1;
              end
            end
          end
          ST_CALC: begin
            count <= count + 5'd1;
            if (count == 5'd31) state <= ST_FIX;
          end
          ST_FIX: begin
            state <= ST_DONE;
            busy  <= 1'b0;
          end
          ST_DONE: begin
            done   <= 1'b1;
            result <= dp_res;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, stall;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // reference: plain 64-bit arithmetic following the RISC-V M rules
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      x, y;
    logic [63:0] p;
    int          ia, ib;
    ia = a;
    ib = b;
    x = rs1_signed(f3) ? longint'($signed(a)) : longint'({32'h0, a});
    y = rs2_signed(f3) ? longint'($signed(b)) : longint'({32'h0, b});
    p = x * y;
    case (f3)
      F3_MUL:                       return p[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: return p[63:32];
      F3_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      F3_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  // Raise start with the operands, accept on the next edge, wait for done.
  // lat counts edges from acceptance to the edge that raises done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int k;
    bit stall_ok, busy_ok;
    bit slow;
    slow     = (model_lat(f3, a, b) == 34);
    funct3   = f3;
    rs1      = a;
    rs2      = b;
    flush    = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    k        = 0;
    lat      = -1;
    stall_ok = 1'b1;
    busy_ok  = 1'b1;
    while (k < 100) begin
      @(posedge clk);
      k++;
      #1;
      if (busy !== ((slow && k <= 32) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    res = result;
    check("stall_while_waiting", 32'(stall_ok), 32'd1);
    check("busy_profile", 32'(busy_ok), 32'd1);
    check("stall_at_done", 32'(stall), 32'd0);
    start = 1'b0;
  endtask

  logic [31:0] r, prev;
  int          lat;
  bit          seen_done;

  initial begin
    vecs[0]  = '{F3_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{F3_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{F3_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    vecs[4]  = '{F3_REM,    32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
    vecs[5]  = '{F3_DIVU,   32'd100,       32'd0,        32'hFFFFFFFF, 1};
    vecs[6]  = '{F3_REMU,   32'd100,       32'd0,        32'd100,      1};
    vecs[7]  = '{F3_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34};
    vecs[8]  = '{F3_MUL,    32'd0,         32'h12345678, 32'h00000000, 34};
    vecs[9]  = '{F3_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34};
    vecs[10] = '{F3_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[11] = '{F3_DIV,    32'd5,         32'd0,        32'hFFFFFFFF, 1};
    vecs[12] = '{F3_REM,    32'd7,         32'hFFFFFFFD, 32'd1,        34};

    // reset state, stall tracks start while done is low
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall_low", 32'(stall), 32'd0);
    start = 1'b1;
    #1;
    check("reset_stall_follows_start", 32'(stall), 32'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // single-cycle done pulse
    @(posedge clk);
    #1;
    check("done_single_pulse", 32'(done), 32'd0);

    // back-to-back: start stays high across the done cycle
    run_op(F3_DIVU, 32'd9, 32'd2, r, lat);
    check("b2b_divu_result", r, 32'd4);
    run_op(F3_MUL, 32'd3, 32'd3, r, lat);
    check("b2b_mul_result", r, 32'd9);
    check("b2b_mul_latency", 32'(lat), 32'd34);
    prev = r;

    // flush at count=10
    funct3 = F3_MUL; rs1 = 32'd1234; rs2 = 32'd5678; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy_after", 32'(busy), 32'd0);
    flush = 1'b0;
    start = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("flush_no_done", 32'(seen_done), 32'd0);
    check("flush_result_kept", result, prev);
    run_op(F3_MUL, 32'd5, 32'd6, r, lat);
    check("after_flush_result", r, 32'd30);
    check("after_flush_latency", 32'(lat), 32'd34);

    // reset mid-CALC
    funct3 = F3_DIVU; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          s;
      f3 = 3'($urandom_range(0, 7));
      s = $urandom_range(0, 5);
      a = (s == 0) ? 32'h80000000 : (s == 1) ? 32'hFFFFFFFF : $urandom;
      s = $urandom_range(0, 5);
      b = (s == 0) ? 32'h0 : (s == 1) ? 32'hFFFFFFFF : $urandom;
      run_op(f3, a, b, r, lat);
      check($sformatf("rand%0d_f3=%0d_a=%h_b=%h", n, f3, a, b), r, model(f3, a, b));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(model_lat(f3, a, b)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
